// File: rtl/hopfield_pkg.sv
// Shared types and helpers for the Hopfield associative memory.
// Holds the controller states and the weight arithmetic helpers.
package hopfield_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LEARN,
    S_RECALL
  } fsm_e;

  // Width of a signed row sum that cannot overflow for n saturated terms.
  function automatic int sum_width(input int n, input int ww);
    int lim;
    lim = n * ((1 << (ww - 1)) - 1) + 1;
    return $clog2(lim) + 2;
  endfunction

  function automatic int sat_add(
    input int w,
    input int delta,
    input int ww
  );
    int mx;
    int s;
    mx = (1 << (ww - 1)) - 1;
    s  = w + delta;
    if (s > mx) s = mx;
    if (s < -mx) s = -mx;
    return s;
  endfunction

endpackage

// File: rtl/hopfield_row_sum.sv
// Signed sum of one weight row against the bipolar neuron vector.
// Each term is +w when the neuron is 1 and -w when it is 0.
module hopfield_row_sum
  import hopfield_pkg::*;
#(
  parameter int N  = 25,
  parameter int WW = 4,
  parameter int SW = 10
) (
  input  logic signed [WW-1:0] row [N],
  input  logic        [N-1:0]  vec,
  output logic signed [SW-1:0] sum
);

  logic signed [SW-1:0] term [N];

  always_comb begin
    for (int m = 0; m < N; m++) begin
      term[m] = {{(SW-WW){row[m][WW-1]}}, row[m]};
      if (!vec[m]) term[m] = -term[m];
    end
  end

  always_comb begin
    sum = '0;
    for (int m = 0; m < N; m++) sum = sum + term[m];
  end

endmodule

// File: rtl/hopfield_assoc_mem.sv
// Hopfield associative memory: Hebbian learning, asynchronous recall.
// One weight row is processed per cycle in every busy state.
module hopfield_assoc_mem
  import hopfield_pkg::*;
#(
  parameter int N          = 25,
  parameter int WW         = 4,
  parameter int MAX_SWEEPS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear_weights,
  input  logic                            learn_valid,
  output logic                            learn_ready,
  input  logic [N-1:0]                    learn_pattern,
  input  logic                            recall_valid,
  output logic                            recall_ready,
  input  logic [N-1:0]                    recall_init,
  output logic [N-1:0]                    state,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [$clog2(MAX_SWEEPS+1)-1:0] sweeps
);

  localparam int SW = sum_width(N, WW);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_SWEEPS + 1);
  localparam logic [KW-1:0] KLAST = KW'(N - 1);
  localparam logic [CW-1:0] SLAST = CW'(MAX_SWEEPS - 1);

  fsm_e                 fsm;
  logic [KW-1:0]        k;
  logic [N-1:0]         pat;
  logic                 chg;
  logic signed [WW-1:0] w   [N][N];
  logic signed [WW-1:0] row [N];
  logic signed [SW-1:0] sum;
  logic                 nb;
  logic                 flip;

  assign learn_ready  = (fsm == S_IDLE);
  assign recall_ready = (fsm == S_IDLE);
  assign busy         = (fsm != S_IDLE);

  always_comb begin
    for (int m = 0; m < N; m++) row[m] = w[k][m];
  end

  hopfield_row_sum #(
    .N (N),
    .WW(WW),
    .SW(SW)
  ) u_sum (
    .row(row),
    .vec(state),
    .sum(sum)
  );

  // Zero sum keeps the current bit so ties never oscillate.
  always_comb begin
    nb = state[k];
    if (sum > 0) nb = 1'b1;
    else if (sum < 0) nb = 1'b0;
  end

  assign flip = nb ^ state[k];

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_IDLE;
      k         <= '0;
      pat       <= '0;
      chg       <= 1'b0;
      state     <= '0;
      done      <= 1'b0;
      converged <= 1'b0;
      sweeps    <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w[i][j] <= '0;
    end else begin
      done <= 1'b0;
      unique case (fsm)
        S_IDLE: begin
          k <= '0;
          if (clear_weights) begin
            fsm <= S_CLEAR;
          end else if (learn_valid) begin
            pat <= learn_pattern;
            fsm <= S_LEARN;
          end else if (recall_valid) begin
            state     <= recall_init;
            sweeps    <= '0;
            converged <= 1'b0;
            chg       <= 1'b0;
            fsm       <= S_RECALL;
          end
        end
        S_CLEAR: begin
          for (int m = 0; m < N; m++) w[k][m] <= '0;
          if (k == KLAST) fsm <= S_IDLE;
          else k <= k + 1'b1;
        end
        S_LEARN: begin
          for (int m = 0; m < N; m++)
            if (m != int'(k))
              w[k][m] <= WW'(sat_add(int'(w[k][m]),
                                     (pat[k] == pat[m]) ? 1 : -1,
                                     WW));
          if (k == KLAST) fsm <= S_IDLE;
          else k <= k + 1'b1;
        end
        S_RECALL: begin
          state[k] <= nb;
          if (k == KLAST) begin
            k      <= '0;
            chg    <= 1'b0;
            sweeps <= sweeps + CW'(1);
            if (!(chg | flip)) begin
              converged <= 1'b1;
              done      <= 1'b1;
              fsm       <= S_IDLE;
            end else if (sweeps == SLAST) begin
              converged <= 1'b0;
              done      <= 1'b1;
              fsm       <= S_IDLE;
            end
          end else begin
            k   <= k + 1'b1;
            chg <= chg | flip;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
